// File: rtl/mux_scanner_pkg.sv
// Shared definitions for the mux scanner: FSM state encodings and default settle time.
package mux_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_SETTLE = 2;

endpackage

// File: rtl/mux_scanner_next.sv
// Combinational finder: lowest enabled channel index strictly above cur_i,
// or the lowest enabled index overall when from_start_i is set.
module mux_scanner_next #(
  parameter int sel_width = 3
) (
  input  logic [2**sel_width-1:0] mask_i,
  input  logic [sel_width-1:0]    cur_i,
  input  logic                    from_start_i,
  output logic [sel_width-1:0]    next_idx_o,
  output logic                    found_o
);

  localparam int N = 2**sel_width;

  // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    found_o    = 1'b0;
    next_idx_o = '0;
    // Walk downwards so the last hit is the lowest qualifying index.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i] && (from_start_i || (i > int'(cur_i)))) begin
        found_o    = 1'b1;
        next_idx_o = sel_width'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scanner.sv
// Scans enabled channels of an external mux: settle, sample, advance, pulse done.
// Optional parity output when MUX_SCANNER_PARITY_EN is defined.
module mux_scanner
  import mux_scanner_pkg::*;
#(
  parameter int sel_width = 3,
  parameter int SETTLE    = DEFAULT_SETTLE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2**sel_width-1:0] ch_mask,
  input  logic                    mux_out,
  output logic [sel_width-1:0]    sel,
  output logic                    busy,
  output logic                    done,
  output logic [2**sel_width-1:0] result
`ifdef MUX_SCANNER_PARITY_EN
  ,
  output logic                    parity
`endif
);

  localparam int N = 2**sel_width;

  state_e                 state_q;
  logic [sel_width-1:0]   sel_q;
  logic [N-1:0]           result_q;
  logic [N-1:0]           mask_q;
  logic [7:0]             cnt_q;
  logic                   done_q;

  logic [N-1:0]           find_mask_d;
  logic                   find_from_start_d;
  logic [sel_width-1:0]   next_idx_d;
  logic                   found_d;

  // One finder serves both the first-channel search (from -1 on the live mask)
  // and the advance to the next channel (above sel on the latched mask).
  always_comb begin
    find_mask_d       = mask_q;
    find_from_start_d = 1'b0;
    if (state_q == ST_IDLE) begin
      find_mask_d       = ch_mask;
      find_from_start_d = 1'b1;
    end
  end

  mux_scanner_next #(
    .sel_width (sel_width)
  ) u_next (
    .mask_i       (find_mask_d),
    .cur_i        (sel_q),
    .from_start_i (find_from_start_d),
    .next_idx_o   (next_idx_d),
    .found_o      (found_d)
  );

`ifdef MUX_SCANNER_PARITY_EN
  logic parity_q;
`endif

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      result_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef MUX_SCANNER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_q   <= ch_mask;
            result_q <= '0;
            cnt_q    <= '0;
            if (found_d) begin
              sel_q   <= next_idx_d;
              state_q <= ST_SETTLE;
            end else begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
`ifdef MUX_SCANNER_PARITY_EN
              parity_q <= 1'b0;
`endif
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q == 8'(SETTLE - 1)) state_q <= ST_SAMPLE;
          else                         cnt_q   <= cnt_q + 8'd1;
        end
        ST_SAMPLE: begin
          result_q[sel_q] <= mux_out;
          if (found_d) begin
            sel_q   <= next_idx_d;
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end else begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
`ifdef MUX_SCANNER_PARITY_EN
            // Bit at sel_q is still 0 here, so folding mux_out in gives the final XOR.
            parity_q <= (^result_q) ^ mux_out;
`endif
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel    = sel_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;
`ifdef MUX_SCANNER_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scanner.sv
// Directed self-checking bench for mux_scanner (sel_width=3, SETTLE=2).
module tb_mux_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] ch_mask;
  logic       mux_out;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [7:0] result;
`ifdef MUX_SCANNER_PARITY_EN
  logic       parity;
`endif

  logic [7:0] pat;
  assign mux_out = pat[sel];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         lat;
  logic [7:0] visited;
  logic [2:0] seq[$];

  always #5 clk = ~clk;

  mux_scanner #(.sel_width(3), .SETTLE(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ch_mask (ch_mask),
    .mux_out (mux_out),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .result  (result)
`ifdef MUX_SCANNER_PARITY_EN
    ,
    .parity  (parity)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts a scan and follows it until done; poke_at >= 0 injects a stray start/mask change.
  task automatic run_scan(input logic [7:0] mask, input int poke_at);
    start   = 1'b1;
    ch_mask = mask;
    tick();
    start   = 1'b0;
    lat     = 0;
    visited = '0;
    seq.delete();
    while (!done && lat < 100) begin
      if (busy) begin
        visited[sel] = 1'b1;
        if (seq.size() == 0 || seq[$] !== sel) seq.push_back(sel);
      end
      start = (lat == poke_at);
      if (lat == poke_at) ch_mask = 8'h01;
      tick();
      lat++;
    end
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ch_mask = '0; pat = '0;
    tick(); tick();
    rst_n = 1'b1;
    n_tests++;
    if ({sel, busy, done, result} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: sel=%0d busy=%b done=%b result=%h, required 0/0/0/00",
               sel, busy, done, result);
    end
  endtask

  task automatic test_full_scan();
    logic ok;
    pat = 8'hA5;
    run_scan(8'hFF, -1);
    n_tests++;
    if (lat !== 24) begin n_fail++; $display("FAIL full_latency: %0d, required 24", lat); end
    n_tests++;
    if (result !== 8'hA5) begin n_fail++; $display("FAIL full_result: %h, required a5", result); end
    ok = (seq.size() == 8);
    for (int i = 0; i < 8 && ok; i++) ok = (seq[i] == 3'(i));
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL full_order: %0d steps, required 0..7", seq.size()); end
`ifdef MUX_SCANNER_PARITY_EN
    n_tests++;
    if (parity !== 1'b0) begin n_fail++; $display("FAIL full_parity: %b, required 0", parity); end
`endif
    tick();
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL full_done_width: busy=%b done=%b, required 0/0", busy, done);
    end
    tick(); tick();
    n_tests++;
    if (result !== 8'hA5 || sel !== 3'd7) begin
      n_fail++; $display("FAIL full_hold: result=%h sel=%0d, required a5/7", result, sel);
    end
  endtask

  task automatic test_sparse_mask();
    pat = 8'h01;
    run_scan(8'h81, -1);
    n_tests++;
    if (lat !== 6) begin n_fail++; $display("FAIL sparse_latency: %0d, required 6", lat); end
    n_tests++;
    if (visited !== 8'h81 || seq.size() != 2) begin
      n_fail++; $display("FAIL sparse_visits: visited=%h steps=%0d, required 81/2", visited, seq.size());
    end
    n_tests++;
    if (result !== 8'h01) begin n_fail++; $display("FAIL sparse_result: %h, required 01", result); end
`ifdef MUX_SCANNER_PARITY_EN
    n_tests++;
    if (parity !== 1'b1) begin n_fail++; $display("FAIL sparse_parity: %b, required 1", parity); end
`endif
    tick();
    pat = 8'hFF;
    run_scan(8'h3C, -1);
    n_tests++;
    if (lat !== 12 || result !== 8'h3C || visited !== 8'h3C || sel !== 3'd5) begin
      n_fail++;
      $display("FAIL mid_mask: lat=%0d result=%h visited=%h sel=%0d, required 12/3c/3c/5",
               lat, result, visited, sel);
    end
    tick();
  endtask

  task automatic test_empty_mask();
    run_scan(8'h00, -1);
    n_tests++;
    if (lat !== 0 || busy !== 1'b1 || result !== 8'h00 || sel !== 3'd5) begin
      n_fail++;
      $display("FAIL empty_done: lat=%0d busy=%b result=%h sel=%0d, required 0/1/00/5",
               lat, busy, result, sel);
    end
    tick();
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL empty_after: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    pat = 8'hA5;
    run_scan(8'hFF, 5);
    n_tests++;
    if (lat !== 24 || result !== 8'hA5) begin
      n_fail++; $display("FAIL ignore_busy: lat=%0d result=%h, required 24/a5", lat, result);
    end
    // Start raised during the DONE cycle must not launch a new scan.
    start = 1'b1; ch_mask = 8'hFF;
    tick();
    start = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b00 || result !== 8'hA5) begin
      n_fail++;
      $display("FAIL ignore_done: busy=%b done=%b result=%h, required 0/0/a5", busy, done, result);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n = 0;
    int dones = 0;
    pat = 8'hA5;
    start = 1'b1; ch_mask = 8'hFF;
    tick();
    start = 1'b0;
    while (sel !== 3'd3 && n < 100) begin tick(); n++; end
    n_tests++;
    if (sel !== 3'd3 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_reach: sel=%0d busy=%b, required 3/1", sel, busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if ({sel, busy, done, result} !== 13'd0) begin
      n_fail++;
      $display("FAIL abort_state: sel=%0d busy=%b done=%b result=%h, required 0/0/0/00",
               sel, busy, done, result);
    end
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      tick();
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: %0d pulses, required 0", dones); end
    run_scan(8'h0F, -1);
    n_tests++;
    if (lat !== 12 || result !== 8'h05) begin
      n_fail++; $display("FAIL abort_restart: lat=%0d result=%h, required 12/05", lat, result);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_empty_mask();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 Parameter: sel_width, default 3, mux select width; channel count N = 2**sel_width.
REQ-002 Parameter: SETTLE, default 2, cycles each select is held before sampling; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  scan request, sampled only in IDLE.
REQ-006 ch_mask  input  N  enabled channels, latched on start acceptance.
REQ-007 mux_out  input  1  output of the downstream mux for the currently driven sel.
REQ-008 sel  output  sel_width  select driven to the mux.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 done  output  1  one-cycle pulse; scan complete, result valid.
REQ-011 result  output  N  captured bit per channel; held until next accepted start.

Function
REQ-012 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE; busy = (state != IDLE).
REQ-013 IDLE with start=1 SHALL, at that edge, latch ch_mask, clear result to 0, and set settle counter to 0.
REQ-014 On acceptance with a nonzero mask, sel SHALL load the lowest-index enabled channel and the state SHALL go to SETTLE.
REQ-015 On acceptance with mask==0, the state SHALL go directly to DONE (done high the next cycle, result 0, sel unchanged).
REQ-016 SETTLE: if counter==SETTLE-1, go to SAMPLE; otherwise increment the counter; sel SHALL be stable throughout.
REQ-017 SAMPLE edge SHALL write result[sel] <= mux_out.
REQ-018 SAMPLE edge: if a higher-index enabled channel remains, sel <= next enabled channel, counter <= 0, state <= SETTLE; otherwise state <= DONE.
REQ-019 Disabled channels SHALL never be driven on sel for settling, and their result bits SHALL stay 0.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-021 Latency: for E enabled channels and start accepted at edge k, done SHALL be high in the cycle after edge k+E*(SETTLE+1).
REQ-022 start while busy, including during DONE, SHALL be ignored, and a mid-scan ch_mask change SHALL have no effect.
REQ-023 sel SHALL never exceed N-1; the scan SHALL not wrap past channel N-1 to 0.

Reset
REQ-024 rst_n=0 at an edge SHALL force state=IDLE, sel=0, result=0, done=0, busy=0, counter=0, and latched mask=0, including mid-scan.
REQ-025 An aborted scan SHALL produce no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-026 Macro MUX_SCANNER_PARITY_EN defined: add output parity (1 bit) = XOR of the final result, registered and valid while done=1, reset to 0.
REQ-027 Macro absent: the parity port and its logic SHALL not exist; all other behaviour is identical.

Structure
REQ-028 Package mux_scanner_pkg SHALL hold the FSM state encodings (2-bit) and the default SETTLE constant.
REQ-029 Sub-module mux_scanner_next SHALL be a combinational finder returning the lowest enabled index above the current sel, plus a found flag; it is reused for first-channel search with a "from -1" input.

Verification (sel_width=3, SETTLE=2)
REQ-030 mask=8'hFF, mux_out=8'hA5[sel], start at edge k -> sel steps 0..7, done after edge k+24, result=8'hA5, parity=0.
REQ-031 mask=8'h81 -> sel visits only 0 then 7, done after edge k+6, result bits 1..6 = 0.
REQ-032 mask=8'h00 -> done high in the cycle right after acceptance, result=0, busy high for that one cycle only.
REQ-033 Second start pulse and mask change during a scan -> ignored, same result and timing as REQ-030.
REQ-034 rst_n low for one edge during SETTLE of channel 3 -> IDLE, sel=0, result=0, no done; a new start then completes normally.
